// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the step/run clock-control front end.
//   ctrl_state_t         : controller FSM state encoding
//   DEF_DEBOUNCE_CYCLES  : default debounce length (board top overrides it)
//   DEF_CNT_W            : default step counter width
//   debounce_cnt_w()     : width needed for a debounce counter of given length
package clk_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } ctrl_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_W           = 16;

  // The debounce counter only ever holds 0 .. cycles-1.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce counter and registered
// rising-edge detect.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   btn_raw : raw, bouncy, asynchronous button input
//   level   : debounced button level
//   press   : one-cycle pulse when the debounced level rises
module btn_debounce
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES  // must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int             CW       = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      press_reg    <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      // Any cycle of agreement restarts the count, so only an unbroken run
      // of DEBOUNCE_CYCLES disagreeing samples moves the stable level.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      stable_d_reg <= stable_reg;
      press_reg    <= stable_reg & ~stable_d_reg;
    end
  end

  assign level = stable_reg;
  assign press = press_reg;

endmodule

// File: rtl/step_run_controller.sv
// Clock-control front end: turns STEP and RUN/STOP buttons plus a CPU halt
// request into a registered one-instruction-per-cycle advance enable.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   btn_step : raw STEP button
//   btn_run  : raw RUN/STOP toggle button
//   halt_in  : synchronous CPU halt request (honored in STEP/RUN only)
//   cpu_en   : registered advance enable (high in STEP and RUN)
//   running  : high while in RUN
//   halted   : high while in HALTED
//   step_cnt : saturating count of cycles with cpu_en high
module step_run_controller
  import clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // must be >= 2
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_cnt
);

  // Bit 0 is STEP, bit 1 is RUN.
  logic [1:0] btn_raw_vec;
  logic [1:0] press_vec;
  logic [1:0] level_unused;

  assign btn_raw_vec = {btn_run, btn_step};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw_vec[gi]),
        .level   (level_unused[gi]),
        .press   (press_vec[gi])
      );
    end
  endgenerate

  logic step_press;
  logic run_press;

  assign step_press = press_vec[0];
  assign run_press  = press_vec[1];

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic             cpu_en_reg;
  logic             running_reg;
  logic             halted_reg;
  logic [CNT_W-1:0] step_cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (run_press) begin
          state_next = RUN;
        end else if (step_press) begin
          state_next = STEP;
        end
      end
      STEP: begin
        state_next = halt_in ? HALTED : IDLE;
      end
      RUN: begin
        // Halt wins over a simultaneous stop press; step presses are ignored.
        if (halt_in) begin
          state_next = HALTED;
        end else if (run_press) begin
          state_next = IDLE;
        end
      end
      HALTED: begin
        if (run_press) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register and carry no combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cpu_en_reg   <= 1'b0;
      running_reg  <= 1'b0;
      halted_reg   <= 1'b0;
      step_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cpu_en_reg  <= (state_next == STEP) || (state_next == RUN);
      running_reg <= (state_next == RUN);
      halted_reg  <= (state_next == HALTED);
      if (cpu_en_reg && (step_cnt_reg != '1)) begin
        step_cnt_reg <= step_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cpu_en   = cpu_en_reg;
  assign running  = running_reg;
  assign halted   = halted_reg;
  assign step_cnt = step_cnt_reg;

endmodule
